// File: rtl/mem_stage_pkg.sv
// Shared definitions for the LEGv8 memory stage: FSM states and wait-counter sizing.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } mem_state_e;

  localparam int DEFAULT_N       = 64;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int RD_W            = 5;

  // Counter must hold the value TIMEOUT itself; never narrower than one bit.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_stage_exmem_reg.sv
// EX/MEM pipeline register: captures the flattened execute bundle when enabled.
module mem_stage_exmem_reg
  import mem_stage_pkg::*;
#(
  parameter int W = 3 * DEFAULT_N + 7 + RD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Load new contents only when the stage is not stalled.
  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // State element; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, req/ack data-memory handshake,
// branch resolution and upstream stall generation.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_E,
  input  logic            MemRead_E,
  input  logic            MemWrite_E,
  input  logic            Branch_E,
  input  logic            RegWrite_E,
  input  logic            MemtoReg_E,
  input  logic [RD_W-1:0] rd_E,
  input  logic [N-1:0]    PCBranch_E,
  input  logic [N-1:0]    aluResult_E,
  input  logic [N-1:0]    writeData_E,
  input  logic            zero_E,
  output logic            dm_req,
  output logic            dm_we,
  output logic [N-1:0]    dm_addr,
  output logic [N-1:0]    dm_wdata,
  input  logic            dm_ack,
  input  logic [N-1:0]    dm_rdata,
  output logic            stall,
  output logic            PCSrc_M,
  output logic [N-1:0]    PCBranch_M,
  output logic            valid_M,
  output logic            RegWrite_M,
  output logic            MemtoReg_M,
  output logic [RD_W-1:0] rd_M,
  output logic [N-1:0]    aluResult_M,
  output logic [N-1:0]    readData_M,
  output logic            memErr_M
);

  localparam int             CW          = wait_cnt_width(TIMEOUT);
  localparam int             BW          = 3 * N + 7 + RD_W;
  localparam logic [CW-1:0]  TIMEOUT_CNT = CW'(TIMEOUT);

  logic [BW-1:0]   bundle_e;
  logic [BW-1:0]   bundle_q;
  logic            valid_q, mem_read_q, mem_write_q, branch_q;
  logic            reg_write_q, memto_reg_q, zero_q;
  logic [RD_W-1:0] rd_q;
  logic [N-1:0]    pc_branch_q, alu_result_q, write_data_q;

  mem_state_e      state_d, state_q;
  logic [CW-1:0]   cnt_d, cnt_q, cnt_inc;
  logic            err_d, err_q;
  logic [N-1:0]    rdata_d, rdata_q;

  logic            mem_op, misalign, incoming_access, load_en;

  assign bundle_e = {valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E,
                     zero_E, rd_E, PCBranch_E, aluResult_E, writeData_E};
  assign {valid_q, mem_read_q, mem_write_q, branch_q, reg_write_q, memto_reg_q,
          zero_q, rd_q, pc_branch_q, alu_result_q, write_data_q} = bundle_q;

  assign load_en = ~stall;

  mem_stage_exmem_reg #(.W(BW)) u_exmem_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .d     (bundle_e),
    .q     (bundle_q)
  );

  assign mem_op          = valid_q & (mem_read_q | mem_write_q);
  assign misalign        = mem_op & (alu_result_q[2:0] != 3'b000);
  assign incoming_access = valid_E & (MemRead_E | MemWrite_E) & (aluResult_E[2:0] == 3'b000);
  assign cnt_inc         = cnt_q + CW'(1);

  // Next-state logic: the FSM decides its next state from whatever EX/MEM loads on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (mem_op && !misalign) state_d = ACCESS;
        else                     state_d = incoming_access ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (dm_ack) begin
          state_d = COMPLETE;
          err_d   = 1'b0;
          if (!mem_write_q) rdata_d = dm_rdata;
        end else if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT)) begin
          state_d = COMPLETE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      COMPLETE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = incoming_access ? ACCESS : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM state, wait counter, error flag and latched load data; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode from the registered state; controls to writeback are gated by valid_M.
  always_comb begin
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    stall    = 1'b0;
    valid_M  = 1'b0;
    memErr_M = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall = 1'b1;
        end else begin
          valid_M  = valid_q;
          memErr_M = misalign;
        end
      end
      ACCESS: begin
        dm_req   = 1'b1;
        dm_we    = mem_write_q;
        dm_addr  = alu_result_q;
        dm_wdata = write_data_q;
        stall    = 1'b1;
      end
      COMPLETE: begin
        valid_M  = 1'b1;
        memErr_M = err_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    RegWrite_M = valid_M & reg_write_q & ~memErr_M;
    MemtoReg_M = valid_M & memto_reg_q;
    rd_M       = valid_M ? rd_q : '0;
    PCSrc_M    = valid_q & branch_q & zero_q & ~stall;
  end

  assign PCBranch_M  = pc_branch_q;
  assign aluResult_M = alu_result_q;
  assign readData_M  = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT = 4).
module tb_mem_stage;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E, zero_E;
  logic [4:0]    rd_E;
  logic [N-1:0]  PCBranch_E, aluResult_E, writeData_E;
  logic          dm_req, dm_we, dm_ack;
  logic [N-1:0]  dm_addr, dm_wdata, dm_rdata;
  logic          stall, PCSrc_M, valid_M, RegWrite_M, MemtoReg_M, memErr_M;
  logic [4:0]    rd_M;
  logic [N-1:0]  PCBranch_M, aluResult_M, readData_M;

  int checks = 0;
  int errors = 0;
  int stallCycles;

  mem_stage #(.N(N), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_E     (valid_E),
    .MemRead_E   (MemRead_E),
    .MemWrite_E  (MemWrite_E),
    .Branch_E    (Branch_E),
    .RegWrite_E  (RegWrite_E),
    .MemtoReg_E  (MemtoReg_E),
    .rd_E        (rd_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .stall       (stall),
    .PCSrc_M     (PCSrc_M),
    .PCBranch_M  (PCBranch_M),
    .valid_M     (valid_M),
    .RegWrite_M  (RegWrite_M),
    .MemtoReg_M  (MemtoReg_M),
    .rd_M        (rd_M),
    .aluResult_M (aluResult_M),
    .readData_M  (readData_M),
    .memErr_M    (memErr_M)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected when it fails.
  task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Return every execute-stage input to an idle bubble.
  task automatic applyStimulus();
    valid_E = 0; MemRead_E = 0; MemWrite_E = 0; Branch_E = 0;
    RegWrite_E = 0; MemtoReg_E = 0; zero_E = 0; rd_E = '0;
    PCBranch_E = '0; aluResult_E = '0; writeData_E = '0;
  endtask

  // Advance one cycle; outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed sequence; inputs change and outputs are sampled on falling edges.
  initial begin
    reset = 0; dm_ack = 0; dm_rdata = '0;
    applyStimulus();
    @(negedge clk); @(negedge clk);
    checkOutput("reset dm_req", dm_req, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset valid_M", valid_M, 0);
    checkOutput("reset readData_M", readData_M, 0);
    checkOutput("reset PCSrc_M", PCSrc_M, 0);
    reset = 1;
    step();

    // ALU op: one-cycle latency through M
    valid_E = 1; RegWrite_E = 1; aluResult_E = 64'h2A; rd_E = 5'd3;
    step();
    applyStimulus();
    checkOutput("alu valid_M", valid_M, 1);
    checkOutput("alu aluResult_M", aluResult_M, 64'h2A);
    checkOutput("alu rd_M", rd_M, 3);
    checkOutput("alu RegWrite_M", RegWrite_M, 1);
    checkOutput("alu stall", stall, 0);

    // Load with ack three cycles after the first request
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; MemtoReg_E = 1; aluResult_E = 64'h100; rd_E = 5'd5;
    step();
    applyStimulus();
    checkOutput("load dm_req", dm_req, 1);
    checkOutput("load dm_we", dm_we, 0);
    checkOutput("load dm_addr", dm_addr, 64'h100);
    checkOutput("load valid_M during access", valid_M, 0);
    stallCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dm_ack = 1; dm_rdata = 64'hDEAD; end
      if (stall) stallCycles++;
      step();
    end
    dm_ack = 0; dm_rdata = '0;
    checkOutput("load stall cycles", stallCycles, 4);
    checkOutput("load valid_M", valid_M, 1);
    checkOutput("load readData_M", readData_M, 64'hDEAD);
    checkOutput("load RegWrite_M", RegWrite_M, 1);
    checkOutput("load MemtoReg_M", MemtoReg_M, 1);
    checkOutput("load rd_M", rd_M, 5);
    checkOutput("load complete stall", stall, 0);
    checkOutput("load complete dm_req", dm_req, 0);
    step();
    checkOutput("load valid_M one cycle", valid_M, 0);

    // Store acknowledged in the same cycle as the request
    valid_E = 1; MemWrite_E = 1; aluResult_E = 64'h08; writeData_E = 64'h55;
    step();
    applyStimulus();
    dm_ack = 1;
    checkOutput("store dm_req", dm_req, 1);
    checkOutput("store dm_we", dm_we, 1);
    checkOutput("store dm_addr", dm_addr, 64'h08);
    checkOutput("store dm_wdata", dm_wdata, 64'h55);
    step();
    dm_ack = 0;
    checkOutput("store valid_M", valid_M, 1);
    checkOutput("store dm_req dropped", dm_req, 0);
    checkOutput("store memErr_M", memErr_M, 0);
    checkOutput("store keeps readData_M", readData_M, 64'hDEAD);
    step();
    checkOutput("store after valid_M", valid_M, 0);

    // Branch taken, then not taken
    valid_E = 1; Branch_E = 1; zero_E = 1; PCBranch_E = 64'h40;
    step();
    checkOutput("branch taken PCSrc_M", PCSrc_M, 1);
    checkOutput("branch PCBranch_M", PCBranch_M, 64'h40);
    zero_E = 0;
    step();
    applyStimulus();
    checkOutput("branch not taken PCSrc_M", PCSrc_M, 0);
    checkOutput("branch hold PCBranch_M", PCBranch_M, 64'h40);

    // Misaligned load: no request, error reported with writeback suppressed
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; aluResult_E = 64'h103; rd_E = 5'd9;
    step();
    applyStimulus();
    checkOutput("misalign dm_req", dm_req, 0);
    checkOutput("misalign memErr_M", memErr_M, 1);
    checkOutput("misalign valid_M", valid_M, 1);
    checkOutput("misalign RegWrite_M", RegWrite_M, 0);
    checkOutput("misalign stall", stall, 0);
    step();
    checkOutput("misalign cleared memErr_M", memErr_M, 0);
    checkOutput("misalign later dm_req", dm_req, 0);

    // Aligned load never acknowledged: abort after four access cycles
    valid_E = 1; MemRead_E = 1; RegWrite_E = 1; aluResult_E = 64'h200; rd_E = 5'd4;
    step();
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput("timeout dm_req held", dm_req, 1);
      step();
    end
    checkOutput("timeout memErr_M", memErr_M, 1);
    checkOutput("timeout valid_M", valid_M, 1);
    checkOutput("timeout RegWrite_M", RegWrite_M, 0);
    checkOutput("timeout dm_req", dm_req, 0);
    checkOutput("timeout readData_M", readData_M, 64'hDEAD);
    step();
    checkOutput("timeout after valid_M", valid_M, 0);

    // Reset asserted in the middle of an access
    valid_E = 1; MemRead_E = 1; aluResult_E = 64'h300;
    step();
    applyStimulus();
    checkOutput("midreset pre dm_req", dm_req, 1);
    #2 reset = 0;
    #1;
    checkOutput("midreset dm_req", dm_req, 0);
    checkOutput("midreset stall", stall, 0);
    checkOutput("midreset valid_M", valid_M, 0);
    checkOutput("midreset readData_M", readData_M, 0);
    @(negedge clk);
    reset = 1;
    step();
    checkOutput("postreset dm_req", dm_req, 0);
    checkOutput("postreset stall", stall, 0);
    valid_E = 1; RegWrite_E = 1; aluResult_E = 64'h10; rd_E = 5'd7;
    step();
    applyStimulus();
    checkOutput("postreset valid_M", valid_M, 1);
    checkOutput("postreset rd_M", rd_M, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
